// File: rtl/mandel_scan_multi.sv
// mandel_scan_multi: multi-lane Mandelbrot frame engine.
// Scans the pixel grid column by column (py inner, px outer). Each pixel is dispatched to the
// lowest-indexed idle iterator lane. Every lane does one full z = z^2 + c step per clock.
// Finished pixels leave through one registered, round-robin write port that honours backpressure.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, abort        frame start (only while idle); frame abort (only while busy)
//   pix_x_max/pix_y_max inclusive last column / row index
//   cxs, cys, dcx, dcy  c at pixel (0,0) and the per-column / per-row steps
//   max_iter            iteration limit
//   busy, done          frame in progress; one-cycle pulse when the frame completes
//   wx, wy, wd, we      framebuffer write: coordinate, colour (0 = in set) and valid
//   wr_ready            sink accepts the write when we && wr_ready
module mandel_scan_multi #(
   parameter int unsigned N_BIT    = 16,
   parameter int unsigned BIT_FRAC = 12,
   parameter int unsigned N_LANE   = 4,
   parameter int unsigned PX_W     = 9,
   parameter int unsigned PY_W     = 8,
   parameter int unsigned IT_W     = 16,
   parameter int unsigned N_COLOR  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PX_W-1:0]  pix_x_max,
   input  logic [PY_W-1:0]  pix_y_max,
   input  logic [N_BIT-1:0] cxs,
   input  logic [N_BIT-1:0] cys,
   input  logic [N_BIT-1:0] dcx,
   input  logic [N_BIT-1:0] dcy,
   input  logic [IT_W-1:0]  max_iter,
   output logic             busy,
   output logic             done,
   output logic [PX_W-1:0]  wx,
   output logic [PY_W-1:0]  wy,
   output logic [2:0]       wd,
   output logic             we,
   input  logic             wr_ready
);

   localparam int unsigned LW = (N_LANE > 1) ? $clog2(N_LANE) : 1;
   localparam logic [N_BIT:0] Four = (N_BIT+1)'(4 << BIT_FRAC);

   typedef enum logic [1:0] {StIdle, StIter, StDone} lane_st_e;

   function automatic logic [N_BIT-1:0] fx_abs(input logic [N_BIT-1:0] v);
      return v[N_BIT-1] ? -v : v;
   endfunction

   // Sign-magnitude product, truncated toward zero, wraps on overflow.
   function automatic logic [N_BIT-1:0] fx_mul(input logic [N_BIT-1:0] a,
                                               input logic [N_BIT-1:0] b);
      logic [2*N_BIT-1:0] p;
      logic [N_BIT-1:0]   t;
      p = {{N_BIT{1'b0}}, fx_abs(a)} * {{N_BIT{1'b0}}, fx_abs(b)};
      t = p[BIT_FRAC+N_BIT-1:BIT_FRAC];
      return (a[N_BIT-1] ^ b[N_BIT-1]) ? -t : t;
   endfunction

   // Frame control, latched config and scanner
   logic             busy_q, done_q, scan_on_q;
   logic [PX_W-1:0]  xmax_q, px_q;
   logic [PY_W-1:0]  ymax_q, py_q;
   logic [N_BIT-1:0] cxs_q, cys_q, dcx_q, dcy_q, cx_q, cy_q;
   logic [IT_W-1:0]  mi_q;

   // Lanes
   lane_st_e         st_q   [N_LANE];
   lane_st_e         st_d   [N_LANE];
   logic [N_BIT-1:0] lx_q   [N_LANE];
   logic [N_BIT-1:0] ly_q   [N_LANE];
   logic [N_BIT-1:0] lcx_q  [N_LANE];
   logic [N_BIT-1:0] lcy_q  [N_LANE];
   logic [PX_W-1:0]  lpx_q  [N_LANE];
   logic [PY_W-1:0]  lpy_q  [N_LANE];
   logic [IT_W-1:0]  li_q   [N_LANE];
   logic [IT_W-1:0]  li_inc [N_LANE];
   logic [N_BIT-1:0] nx     [N_LANE];
   logic [N_BIT-1:0] ny     [N_LANE];
   logic [N_LANE-1:0] esc;

   // Write port
   logic             we_q;
   logic [PX_W-1:0]  wx_q;
   logic [PY_W-1:0]  wy_q;
   logic [2:0]       wd_q;
   logic [LW-1:0]    rr_q;

   logic start_fire, abort_fire;
   logic any_idle, all_idle, disp_en, out_load, gnt_en;
   logic [LW-1:0]   disp_lane, gnt_lane, idx;
   logic [IT_W-1:0] col_it, col_mod;
   logic [2:0]      col;

   assign start_fire = start && !busy_q;
   assign abort_fire = abort && busy_q;
   assign out_load   = !we_q || wr_ready;

   // One iteration step per lane, escape test on the new values
   always_comb begin
      for (int l = 0; l < int'(N_LANE); l++) begin
         nx[l]     = fx_mul(lx_q[l], lx_q[l]) - fx_mul(ly_q[l], ly_q[l]) + lcx_q[l];
         ny[l]     = (fx_mul(lx_q[l], ly_q[l]) << 1) + lcy_q[l];
         esc[l]    = ({1'b0, fx_abs(nx[l])} + {1'b0, fx_abs(ny[l])}) >= Four;
         li_inc[l] = li_q[l] + IT_W'(1);
      end
   end

   // Lane FSM outputs: dispatch target, round-robin grant, colour of granted lane
   always_comb begin
      any_idle  = 1'b0;
      all_idle  = 1'b1;
      disp_lane = '0;
      for (int l = int'(N_LANE) - 1; l >= 0; l--) begin
         if (st_q[l] == StIdle) begin
            any_idle  = 1'b1;
            disp_lane = LW'(l);
         end else begin
            all_idle = 1'b0;
         end
      end
      disp_en  = scan_on_q && any_idle && !abort_fire;
      gnt_en   = 1'b0;
      gnt_lane = '0;
      idx      = '0;
      for (int k = 1; k <= int'(N_LANE); k++) begin
         idx = LW'((int'(rr_q) + k) % int'(N_LANE));
         if (!gnt_en && st_q[idx] == StDone) begin
            gnt_en   = 1'b1;
            gnt_lane = idx;
         end
      end
      gnt_en  = gnt_en && out_load && !abort_fire;
      col_it  = li_q[gnt_lane];
      col_mod = col_it % IT_W'(N_COLOR);
      col     = (col_it == mi_q) ? 3'd0 : col_mod[2:0] + 3'd1;
   end

   // Lane FSM next state
   always_comb begin
      for (int l = 0; l < int'(N_LANE); l++) begin
         st_d[l] = st_q[l];
         unique case (st_q[l])
            StIdle: if (disp_en && disp_lane == LW'(l)) st_d[l] = StIter;
            StIter: if (mi_q == '0 || esc[l] || li_inc[l] == mi_q) st_d[l] = StDone;
            StDone: if (gnt_en && gnt_lane == LW'(l)) st_d[l] = StIdle;
            default: st_d[l] = StIdle;
         endcase
         if (abort_fire) st_d[l] = StIdle;
      end
   end

   // Lane FSM state register
   always_ff @(posedge clk) begin
      for (int l = 0; l < int'(N_LANE); l++) begin
         if (rst) st_q[l] <= StIdle;
         else     st_q[l] <= st_d[l];
      end
   end

   // Lane datapath; an escaped or exhausted lane keeps i for the colour lookup
   always_ff @(posedge clk) begin
      for (int l = 0; l < int'(N_LANE); l++) begin
         if (st_q[l] == StIdle && disp_en && disp_lane == LW'(l)) begin
            lx_q[l]  <= '0;
            ly_q[l]  <= '0;
            li_q[l]  <= '0;
            lcx_q[l] <= cx_q;
            lcy_q[l] <= cy_q;
            lpx_q[l] <= px_q;
            lpy_q[l] <= py_q;
         end else if (st_q[l] == StIter && mi_q != '0 && !esc[l]) begin
            lx_q[l] <= nx[l];
            ly_q[l] <= ny[l];
            li_q[l] <= li_inc[l];
         end
      end
   end

   // Frame control and scanner
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         scan_on_q <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         xmax_q    <= '0;
         ymax_q    <= '0;
         cxs_q     <= '0;
         cys_q     <= '0;
         dcx_q     <= '0;
         dcy_q     <= '0;
         mi_q      <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort_fire) begin
            busy_q    <= 1'b0;
            scan_on_q <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
         end else if (start_fire) begin
            xmax_q    <= pix_x_max;
            ymax_q    <= pix_y_max;
            cxs_q     <= cxs;
            cys_q     <= cys;
            dcx_q     <= dcx;
            dcy_q     <= dcy;
            mi_q      <= max_iter;
            busy_q    <= 1'b1;
            scan_on_q <= 1'b1;
            px_q      <= '0;
            py_q      <= '0;
            cx_q      <= cxs;
            cy_q      <= cys;
         end else begin
            if (disp_en) begin
               if (py_q == ymax_q) begin
                  py_q <= '0;
                  cy_q <= cys_q;
                  if (px_q == xmax_q) begin
                     scan_on_q <= 1'b0;
                  end else begin
                     px_q <= px_q + PX_W'(1);
                     cx_q <= cx_q + dcx_q;
                  end
               end else begin
                  py_q <= py_q + PY_W'(1);
                  cy_q <= cy_q + dcy_q;
               end
            end
            if (busy_q && !scan_on_q && all_idle && !we_q) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   // Write port register
   always_ff @(posedge clk) begin
      if (rst || abort_fire) begin
         we_q <= 1'b0;
         wx_q <= '0;
         wy_q <= '0;
         wd_q <= '0;
         rr_q <= LW'(N_LANE - 1);
      end else if (out_load) begin
         we_q <= gnt_en;
         if (gnt_en) begin
            wx_q <= lpx_q[gnt_lane];
            wy_q <= lpy_q[gnt_lane];
            wd_q <= col;
            rr_q <= gnt_lane;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign we   = we_q;
   assign wx   = wx_q;
   assign wy   = wy_q;
   assign wd   = wd_q;

endmodule

// File: tb/tb_mandel_scan_multi.sv
// Testbench for mandel_scan_multi: directed frames, out-of-order scoreboard on the write port.
module tb_mandel_scan_multi;

   logic        clk = 1'b0;
   logic        rst, start, abort, wr_ready;
   logic [8:0]  pix_x_max;
   logic [7:0]  pix_y_max;
   logic [15:0] cxs, cys, dcx, dcy, max_iter;
   logic        busy, done, we;
   logic [8:0]  wx;
   logic [7:0]  wy;
   logic [2:0]  wd;

   mandel_scan_multi dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pix_x_max(pix_x_max), .pix_y_max(pix_y_max),
      .cxs(cxs), .cys(cys), .dcx(dcx), .dcy(dcy), .max_iter(max_iter),
      .busy(busy), .done(done), .wx(wx), .wy(wy), .wd(wd), .we(we), .wr_ready(wr_ready)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int y; int wd; } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail = 0;
   int n_writes = 0;
   int n_done = 0;
   logic        hold_pending = 1'b0;
   logic [20:0] hold_val = '0;

   function automatic int wrap16(longint v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   function automatic int iabs(int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic int fmul(int a, int b);
      longint m, t;
      m = longint'(iabs(a)) * longint'(iabs(b));
      t = (m >> 12) & 64'hFFFF;
      if ((a < 0) != (b < 0)) t = -t;
      return wrap16(t);
   endfunction

   // Golden colour for one pixel
   function automatic int model_wd(int cx, int cy, int mi);
      int x, y, nx, ny;
      x = 0;
      y = 0;
      if (mi == 0) return 0;
      for (int i = 0; i < mi; i++) begin
         nx = wrap16(longint'(fmul(x, x) - fmul(y, y) + cx));
         ny = wrap16(longint'(2 * fmul(x, y) + cy));
         if (iabs(nx) + iabs(ny) >= 4 * 4096) return (i % 7) + 1;
         x = nx;
         y = ny;
      end
      return 0;
   endfunction

   task automatic push_frame(int xm, int ym, int c0x, int c0y, int dx, int dy, int mi);
      int cx, cy;
      for (int px = 0; px <= xm; px++) begin
         for (int py = 0; py <= ym; py++) begin
            cx = wrap16(longint'(c0x + px * dx));
            cy = wrap16(longint'(c0y + py * dy));
            sb.push_back('{px, py, model_wd(cx, cy, mi)});
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic start_frame(int xm, int ym, int c0x, int c0y, int dx, int dy, int mi);
      n_writes  = 0;
      n_done    = 0;
      pix_x_max = 9'(xm);
      pix_y_max = 8'(ym);
      cxs       = 16'(c0x);
      cys       = 16'(c0y);
      dcx       = 16'(dx);
      dcy       = 16'(dy);
      max_iter  = 16'(mi);
      start     = 1'b1;
      cycle();
      start     = 1'b0;
   endtask

   task automatic wait_done(string name, int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         cycle();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, int'(seen), 1);
      check({name, "_busy_at_done"}, int'(busy), 0);
   endtask

   task automatic frame_end(string name, int nexp);
      cycle();
      check({name, "_done_pulses"}, n_done, 1);
      check({name, "_done_low"}, int'(done), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_writes"}, n_writes, nexp);
      check({name, "_pending"}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_idle_outputs(string name);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_done"}, int'(done), 0);
      check({name, "_we"}, int'(we), 0);
      check({name, "_wx"}, int'(wx), 0);
      check({name, "_wy"}, int'(wy), 0);
      check({name, "_wd"}, int'(wd), 0);
   endtask

   // Monitor: matches accepted writes against outstanding pixels, checks hold under backpressure
   always @(negedge clk) begin : mon
      int found;
      if (!rst) begin
         if (hold_pending) begin
            n_tests++;
            if ({we, wx, wy, wd} !== hold_val) begin
               n_fail++;
               $display("FAIL bp_hold: got we/wx/wy/wd=%b/%0d/%0d/%0d, required %b/%0d/%0d/%0d",
                        we, wx, wy, wd, hold_val[20], hold_val[19:11], hold_val[10:3],
                        hold_val[2:0]);
            end
         end
         if (we && wr_ready) begin
            found = -1;
            for (int k = 0; k < sb.size(); k++)
               if (sb[k].x == int'(wx) && sb[k].y == int'(wy)) found = k;
            n_tests++;
            n_writes++;
            if (found < 0) begin
               n_fail++;
               $display("FAIL write_unexpected: got (%0d,%0d) wd=%0d, required an outstanding pixel",
                        wx, wy, wd);
            end else begin
               if (sb[found].wd != int'(wd)) begin
                  n_fail++;
                  $display("FAIL write_colour (%0d,%0d): got wd=%0d, required %0d",
                           wx, wy, wd, sb[found].wd);
               end
               sb.delete(found);
            end
         end
         if (done) n_done++;
      end
      hold_pending = !rst && we && !wr_ready;
      hold_val     = {we, wx, wy, wd};
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of run, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
      pix_x_max = '0; pix_y_max = '0; cxs = '0; cys = '0; dcx = '0; dcy = '0; max_iter = '0;
      repeat (3) cycle();
      rst = 1'b0;
      check_idle_outputs("reset");

      // 1x1 grid, c=0, max_iter=3: in set, we rises 5 edges after the start edge
      sb.push_back('{0, 0, 0});
      start_frame(0, 0, 0, 0, 0, 0, 3);
      k = 0;
      while (!we && k < 20) begin
         cycle();
         k++;
      end
      check("t1_latency", k, 5);
      wait_done("t1", 50);
      frame_end("t1", 1);

      // cx=2.0 escapes at i=1 -> colour 2; cx=-2.0 stays at 2.0 -> in set
      sb.push_back('{0, 0, 2});
      start_frame(0, 0, 'h2000, 0, 0, 0, 100);
      wait_done("t2a", 200);
      frame_end("t2a", 1);
      sb.push_back('{0, 0, 0});
      start_frame(0, 0, 'hE000, 0, 0, 0, 100);
      wait_done("t2b", 300);
      frame_end("t2b", 1);

      // 2x3 grid; config inputs scrambled after start must be ignored
      push_frame(1, 2, 'hE000, 'hF000, 'h20, 'h20, 100);
      start_frame(1, 2, 'hE000, 'hF000, 'h20, 'h20, 100);
      pix_x_max = 9'd5; pix_y_max = 8'd7; cxs = '0; cys = '0; max_iter = 16'd1;
      wait_done("t3", 2000);
      frame_end("t3", 6);

      // Backpressure for 20 cycles once the first write appears
      push_frame(2, 2, 'hE000, 'hF000, 'h400, 'h400, 20);
      start_frame(2, 2, 'hE000, 'hF000, 'h400, 'h400, 20);
      k = 0;
      while (!we && k < 200) begin
         cycle();
         k++;
      end
      check("t4_we_seen", int'(we), 1);
      wr_ready = 1'b0;
      repeat (20) cycle();
      wr_ready = 1'b1;
      wait_done("t4", 2000);
      frame_end("t4", 9);

      // Abort a long frame, then run a fresh one
      push_frame(1, 1, 0, 0, 'h100, 'h100, 200);
      start_frame(1, 1, 0, 0, 'h100, 'h100, 200);
      repeat (10) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      check("t5_abort_we", int'(we), 0);
      check("t5_abort_busy", int'(busy), 0);
      repeat (10) cycle();
      check("t5_abort_no_done", n_done, 0);
      check("t5_abort_still_idle", int'(busy), 0);
      sb.delete();
      push_frame(1, 1, 'h800, 0, 'h800, 'h800, 5);
      start_frame(1, 1, 'h800, 0, 'h800, 'h800, 5);
      wait_done("t5", 500);
      frame_end("t5", 4);

      // max_iter=0 with reset mid-frame, then a full frame
      push_frame(2, 2, 'h1000, 'h1000, 'h400, 'h400, 0);
      start_frame(2, 2, 'h1000, 'h1000, 'h400, 'h400, 0);
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      check_idle_outputs("t6_rst");
      rst = 1'b0;
      sb.delete();
      cycle();
      push_frame(2, 2, 'h1000, 'h1000, 'h400, 'h400, 0);
      start_frame(2, 2, 'h1000, 'h1000, 'h400, 'h400, 0);
      wait_done("t6", 500);
      frame_end("t6", 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
